mem_access_unit: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 23 ++
 rtl/mem_byte_lane.sv | 42 ++++
 rtl/mem_access_unit.sv | 175 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and lane constants for the MIPS load/store path.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } mau_state_t;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / BYTE_W;

endpackage

// File: rtl/mem_byte_lane.sv
// Little-endian byte/half lane extract (with sign/zero extension) and
// read-modify-write merge for a 32-bit word.
module mem_byte_lane
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] ext_data,
  output logic [31:0] merge_data
);

  logic [BYTE_W-1:0] lane_b;
  logic [HALF_W-1:0] lane_h;

  always_comb begin
    lane_b     = rdata[{offset, 3'b000} +: BYTE_W];
    lane_h     = offset[1] ? rdata[31:16] : rdata[15:0];
    ext_data   = rdata;
    merge_data = wdata;
    case (size)
      BYTE: begin
        ext_data   = {{(WORD_W-BYTE_W){sign_ext & lane_b[BYTE_W-1]}}, lane_b};
        merge_data = rdata;
        merge_data[{offset, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      end
      HALF: begin
        ext_data   = {{(WORD_W-HALF_W){sign_ext & lane_h[HALF_W-1]}}, lane_h};
        merge_data = rdata;
        if (offset[1]) merge_data[31:16] = wdata[HALF_W-1:0];
        else           merge_data[15:0]  = wdata[HALF_W-1:0];
      end
      default: begin
        ext_data   = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller turning byte/half/word requests into RAM word cycles.
// Define MEM_ACCESS_ALIGN_TRAP_EN to trap misaligned requests instead of masking them.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  generate
    if (DATA_W != 32) begin : g_bad_width
      $error("mem_access_unit supports DATA_W = 32 only");
    end
  endgenerate

  mau_state_t        state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [1:0]        off_q, off_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ram_in_q, ram_in_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        size_n;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] acc_addr;
  logic              trap;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] merge_data;

  // Encoding 2'b11 is treated as a word access.
  assign size_n = (req_size == 2'b11) ? WORD : req_size;

`ifdef MEM_ACCESS_ALIGN_TRAP_EN
  assign trap     = ((size_n == HALF) && req_address[0]) ||
                    ((size_n == WORD) && (req_address[1:0] != 2'b00));
  assign eff_addr = req_address;
`else
  assign trap = 1'b0;
  always_comb begin
    eff_addr = req_address;
    if (size_n == HALF) eff_addr[0]   = 1'b0;
    if (size_n == WORD) eff_addr[1:0] = 2'b00;
  end
`endif

  assign acc_addr = (size_n == WORD) ? eff_addr : {eff_addr[ADDR_W-1:2], 2'b00};

  mem_byte_lane u_lane (
    .rdata      (ram_out),
    .wdata      (wdata_q),
    .offset     (off_q),
    .size       (size_q),
    .sign_ext   (sign_q),
    .ext_data   (ext_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    sign_d   = sign_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    error_d  = error_q;
    addr_d   = addr_q;
    ram_in_d = ram_in_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = size_n;
          sign_d  = req_signed;
          off_d   = eff_addr[1:0];
          wdata_d = req_wdata;
          addr_d  = acc_addr;
          rdata_d = '0;
          error_d = 1'b0;
          if (trap) begin
            error_d = 1'b1;
            state_d = RESP;
          end else if (req_write && (size_n == WORD)) begin
            ram_in_d = req_wdata;
            state_d  = WR;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: state_d = RD_DATA;
      // RAM read data is valid here; either format it or merge it for the write-back.
      RD_DATA: begin
        if (write_q) begin
          ram_in_d = merge_data;
          state_d  = WR;
        end else begin
          rdata_d = ext_data;
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    we_d    = (state_d == WR);
    valid_d = (state_d == RESP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      sign_q   <= 1'b0;
      off_q    <= 2'b00;
      wdata_q  <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      ram_in_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      ram_in_q <= ram_in_d;
      rdata_q  <= rdata_d;
    end
  end

  assign req_ready        = ready_q;
  assign resp_valid       = valid_q;
  assign resp_rdata       = rdata_q;
  assign resp_error       = error_q;
  assign ram_write_enable = we_q;
  assign ram_address      = addr_q;
  assign ram_in           = ram_in_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit against a one-cycle-latency word RAM model.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        ram_write_enable;
  logic [31:0] ram_address;
  logic [31:0] ram_in;
  logic [31:0] ram_out;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_address      (req_address),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_in           (ram_in),
    .ram_out          (ram_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [0:63];
  always @(posedge clock) begin
    if (ram_write_enable) mem[ram_address[7:2]] <= ram_in;
    ram_out <= mem[ram_address[7:2]];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int last_resp_cyc = -10;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Monitor: pops one expectation per resp_valid pulse.
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      we_cnt = 0;
    end else begin
      if (ram_write_enable) we_cnt++;
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d want no response", cyc);
        end else begin
          e = exp_q.pop_front();
          cmp({e.name, "_rdata"}, resp_rdata, e.rdata);
          cmp({e.name, "_error"}, {31'd0, resp_error}, {31'd0, e.err});
          cmp({e.name, "_latency"}, cyc - e.acc, e.lat);
          cmp({e.name, "_we_cycles"}, we_cnt, e.we);
        end
        we_cnt = 0;
        last_resp_cyc = cyc;
      end
    end
  end

  task automatic issue(input string nm, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                       input logic ee, input int el, input int ewe, input bit b2b, input bit keep);
    int w;
    exp_t e;
    w = 0;
    req_valid   = 1'b1;
    req_write   = wr;
    req_size    = sz;
    req_signed  = sg;
    req_address = a;
    req_wdata   = wd;
    while (!req_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept: got no accept want accept within 50 cycles", nm);
      req_valid = 1'b0;
      return;
    end
    if (b2b) cmp({nm, "_accept_cycle"}, cyc, last_resp_cyc + 1);
    e.name = nm; e.rdata = er; e.err = ee; e.lat = el; e.we = ewe; e.acc = cyc;
    exp_q.push_back(e);
    @(negedge clock);
    cmp({nm, "_busy_ready"}, {31'd0, req_ready}, 32'd0);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clock);
      w++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending responses want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic check_reset(input string nm);
    cmp({nm, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    cmp({nm, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    cmp({nm, "_resp_error"}, {31'd0, resp_error}, 32'd0);
    cmp({nm, "_ram_we"}, {31'd0, ram_write_enable}, 32'd0);
    cmp({nm, "_ram_address"}, ram_address, 32'd0);
    cmp({nm, "_ram_in"}, ram_in, 32'd0);
    cmp({nm, "_resp_rdata"}, resp_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] pre_val;

  initial begin
    int w;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_address = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clock);
    check_reset("rst_hold");
    #2 reset_n = 1'b1;
    @(negedge clock);
    check_reset("rst_release");

    // Word store then word load
    issue("sw_10", 1'b1, WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 1'b0, 1'b0);
    drain();
    issue("lw_10_a", 1'b0, WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 1'b0, 1'b0);
    drain();

    // Byte store via read-modify-write
    issue("sb_12", 1'b1, BYTE, 1'b0, 32'h12, 32'h00000055, 32'h0, 1'b0, 4, 1, 1'b0, 1'b0);
    drain();
    issue("lw_10_b", 1'b0, WORD, 1'b0, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0, 3, 0, 1'b0, 1'b0);
    drain();

    // Sub-word loads with sign/zero extension
    issue("lb_13", 1'b0, BYTE, 1'b1, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 3, 0, 1'b0, 1'b0);
    drain();
    issue("lbu_13", 1'b0, BYTE, 1'b0, 32'h13, 32'h0, 32'h000000DE, 1'b0, 3, 0, 1'b0, 1'b0);
    drain();
    issue("lh_10", 1'b0, HALF, 1'b1, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 3, 0, 1'b0, 1'b0);
    drain();
    issue("lhu_12", 1'b0, HALF, 1'b0, 32'h12, 32'h0, 32'h0000DE55, 1'b0, 3, 0, 1'b0, 1'b0);
    drain();

    // Misaligned half store
`ifdef MEM_ACCESS_ALIGN_TRAP_EN
    issue("sh_11_trap", 1'b1, HALF, 1'b0, 32'h11, 32'h00001234, 32'h0, 1'b1, 1, 0, 1'b0, 1'b0);
    drain();
    pre_val = 32'hDE55BEEF;
`else
    issue("sh_11_mask", 1'b1, HALF, 1'b0, 32'h11, 32'h00001234, 32'h0, 1'b0, 4, 1, 1'b0, 1'b0);
    drain();
    pre_val = 32'hDE551234;
`endif
    issue("lw_10_c", 1'b0, WORD, 1'b0, 32'h10, 32'h0, pre_val, 1'b0, 3, 0, 1'b0, 1'b0);
    drain();

    // Reset during the write phase of a byte store
    req_valid = 1'b1; req_write = 1'b1; req_size = BYTE; req_signed = 1'b0;
    req_address = 32'h10; req_wdata = 32'h000000AA;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    @(negedge clock);
    req_valid = 1'b0;
    w = 0;
    while (!ram_write_enable && w < 20) begin
      @(negedge clock);
      w++;
    end
    cmp("rst_we_seen", {31'd0, ram_write_enable}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    cmp("rst_we_async_drop", {31'd0, ram_write_enable}, 32'd0);
    cmp("rst_ready_async", {31'd0, req_ready}, 32'd1);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    check_reset("rst_mid");
    repeat (3) @(negedge clock);
    issue("lw_10_d", 1'b0, WORD, 1'b0, 32'h10, 32'h0, pre_val, 1'b0, 3, 0, 1'b0, 1'b0);
    drain();

    // Back-to-back loads with req_valid held high
    issue("b2b_lw", 1'b0, WORD, 1'b0, 32'h10, 32'h0, pre_val, 1'b0, 3, 0, 1'b0, 1'b1);
    issue("b2b_lbu", 1'b0, BYTE, 1'b0, 32'h11, 32'h0, {24'd0, pre_val[15:8]}, 1'b0, 3, 0, 1'b1, 1'b1);
    issue("b2b_lh", 1'b0, HALF, 1'b1, 32'h12, 32'h0, 32'hFFFFDE55, 1'b0, 3, 0, 1'b1, 1'b0);
    drain();
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
